lsu_dma: RTL and testbench

Word-copy engine that acts as a request initiator on the LSU port (address / store data / size / write-enable in, load data out). It copies a block of 32-bit words from a source address to a destination address, one load and one store per word. The same address map applies, so it can move data between RAM and the IO window (LEDR/LEDG/HEX/LCD, switches). It sits beside the core's MEM stage and owns the LSU port while busy; the external arbiter gives it the port whenever o_busy is high.

---
 rtl/lsu_dma.sv | 148 ++++++++++++++
 tb/tb_lsu_dma.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dma.sv
// rtl/lsu_dma.sv - word-copy engine driving the LSU request port
module lsu_dma #(
    parameter int LD_LATENCY = 1,
    parameter int LEN_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [31:0]      i_src_addr,
    input  logic [31:0]      i_dst_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [31:0]      o_lsu_addr,
    output logic [31:0]      o_st_data,
    output logic [1:0]       o_lsu_size,
    output logic             o_lsu_wren,
    input  logic [31:0]      i_ld_data
);

    localparam int WAIT_W = $clog2(LD_LATENCY) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q, err_d;

    // State and datapath registers; reset aborts any copy in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: one load, LD_LATENCY wait cycles, one store per word.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    src_d = i_src_addr;
                    dst_d = i_dst_addr;
                    cnt_d = i_len;
                    err_d = 1'b0;
                    if ((i_src_addr[1:0] != 2'b00) || (i_dst_addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (i_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                wait_d  = WAIT_W'(LD_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    data_d  = i_ld_data;
                    state_d = S_WR;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_WR: begin
                src_d = src_q + 32'd4;
                dst_d = dst_q + 32'd4;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only, so reset clears them at once.
    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_lsu_wren = 1'b0;
        o_lsu_addr = 32'd0;
        o_st_data  = 32'd0;
        case (state_q)
            S_RD, S_WAIT: begin
                o_busy     = 1'b1;
                o_lsu_addr = src_q;
            end
            S_WR: begin
                o_busy     = 1'b1;
                o_lsu_wren = 1'b1;
                o_lsu_addr = dst_q;
                o_st_data  = data_q;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_err      = err_q;
    assign o_lsu_size = 2'b10;

endmodule

// File: tb/tb_lsu_dma.sv
// tb/tb_lsu_dma.sv - scoreboard bench for lsu_dma with an LSU memory/IO model
module tb_lsu_dma;

    localparam logic [31:0] LEDR_ADDR = 32'h1000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_src_addr = 32'd0;
    logic [31:0] i_dst_addr = 32'd0;
    logic [15:0] i_len = 16'd0;
    logic        o_busy, o_done, o_err, o_lsu_wren;
    logic [31:0] o_lsu_addr, o_st_data, i_ld_data;
    logic [1:0]  o_lsu_size;

    lsu_dma #(.LD_LATENCY(1), .LEN_W(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_lsu_size(o_lsu_size),
        .o_lsu_wren(o_lsu_wren), .i_ld_data(i_ld_data)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // LSU model: registered read, RAM plus an LEDR register in the IO window.
    logic [31:0] mem [0:1023];
    logic [31:0] io_ledr = 32'd0;
    logic [31:0] ld_q = 32'd0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_data = 32'd0;
    assign i_ld_data = ld_q;

    always @(posedge i_clk) begin
        ld_q <= (o_lsu_addr == LEDR_ADDR) ? io_ledr : mem[o_lsu_addr[11:2]];
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (o_lsu_wren) begin
            if (o_lsu_addr == LEDR_ADDR) io_ledr <= o_st_data;
            else mem[o_lsu_addr[11:2]] <= o_st_data;
        end
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } st_t;
    typedef struct { logic [31:0] addr; int cyc; } rd_t;
    typedef struct { int cyc; logic err; int busy; } done_t;

    st_t   stq[$];
    rd_t   rdq[$];
    done_t doneq[$];
    logic [31:0] exp_d [0:7];

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a load, store or done.
    always @(negedge i_clk) begin
        if (i_reset) begin
            check("lsu_size", {30'd0, o_lsu_size}, 32'd2);
            if (o_lsu_wren) begin
                if (stq.size() == 0) begin
                    check("unexpected_store_addr", o_lsu_addr, 32'hxxxx_xxxx);
                end else begin
                    st_t e;
                    e = stq.pop_front();
                    check("st_addr", o_lsu_addr, e.addr);
                    check("st_data", o_st_data, e.data);
                    check("st_cycle", cyc, e.cyc);
                end
            end
            if (rdq.size() > 0 && cyc >= rdq[0].cyc) begin
                rd_t r;
                r = rdq.pop_front();
                check("rd_cycle", cyc, r.cyc);
                check("rd_addr", o_lsu_addr, r.addr);
                check("rd_wren", {31'd0, o_lsu_wren}, 32'd0);
            end
            if (o_done) begin
                if (doneq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = doneq.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_err", {31'd0, o_err}, {31'd0, d.err});
                    check("busy_len", busy_cnt, d.busy);
                end
                busy_cnt = 0;
            end else if (o_busy) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
            if (!o_busy) begin
                check("idle_addr", o_lsu_addr, 32'd0);
                check("idle_st", o_st_data, 32'd0);
                check("idle_wren", {31'd0, o_lsu_wren}, 32'd0);
            end
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_en = 1'b1;
        pl_idx = addr[11:2];
        pl_data = data;
        @(negedge i_clk);
        pl_en = 1'b0;
    endtask

    // Issues a start and pushes the expected reads, stores (data from exp_d) and done.
    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n, output int k);
        logic bad;
        k = cyc;
        bad = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        i_start = 1'b1;
        i_src_addr = s;
        i_dst_addr = d;
        i_len = 16'(n);
        if (bad || n == 0) begin
            doneq.push_back('{k + 1, bad, 0});
        end else begin
            for (int i = 0; i < n; i++) begin
                rdq.push_back('{s + 32'(4 * i), k + 1 + 3 * i});
                stq.push_back('{d + 32'(4 * i), exp_d[i], k + 3 + 3 * i});
            end
            doneq.push_back('{k + 1 + 3 * n, 1'b0, 3 * n});
        end
        @(negedge i_clk);
        i_start = 1'b0;
        i_src_addr = 32'd0;
        i_dst_addr = 32'd0;
        i_len = 16'd0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((doneq.size() != 0 || stq.size() != 0 || rdq.size() != 0) && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 200) begin
            check("timeout_pending", doneq.size() + stq.size() + rdq.size(), 32'd0);
            doneq.delete();
            stq.delete();
            rdq.delete();
        end
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        #3;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_wren", {31'd0, o_lsu_wren}, 32'd0);
        check("rst_addr", o_lsu_addr, 32'd0);
        check("rst_st", o_st_data, 32'd0);
        check("rst_size", {30'd0, o_lsu_size}, 32'd2);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);

        // Single word copy 0x0 -> 0x100.
        preload(32'h0, 32'h1122_3344);
        exp_d[0] = 32'h1122_3344;
        start_copy(32'h0, 32'h100, 1, k);
        wait_idle();
        check("mem_0x100", mem[64], 32'h1122_3344);

        // Four-word block 0x0 -> 0x200.
        preload(32'h0, 32'hA0);
        preload(32'h4, 32'hA1);
        preload(32'h8, 32'hA2);
        preload(32'hC, 32'hA3);
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
        start_copy(32'h0, 32'h200, 4, k);
        wait_idle();

        // Zero length, then misaligned source with sticky error.
        start_copy(32'h0, 32'h300, 0, k);
        wait_idle();
        start_copy(32'h2, 32'h300, 1, k);
        wait_idle();
        check("err_sticky_idle", {31'd0, o_err}, 32'd1);

        // Wrap-around source; the valid start also clears o_err.
        preload(32'hFFFF_FFFC, 32'hCAFE_0001);
        preload(32'h0, 32'hCAFE_0002);
        exp_d[0] = 32'hCAFE_0001; exp_d[1] = 32'hCAFE_0002;
        start_copy(32'hFFFF_FFFC, 32'h300, 2, k);
        @(negedge i_clk);
        check("err_cleared", {31'd0, o_err}, 32'd0);
        wait_idle();

        // Reset during the store of word 2 of a 4-word copy.
        preload(32'h0, 32'hB0);
        preload(32'h4, 32'hB1);
        exp_d[0] = 32'hB0; exp_d[1] = 32'hB1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
        start_copy(32'h0, 32'h400, 4, k);
        while (cyc < k + 6) @(negedge i_clk);
        #2 i_reset = 1'b0;
        #1;
        check("rst_mid_wren", {31'd0, o_lsu_wren}, 32'd0);
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        check("rst_mid_done", {31'd0, o_done}, 32'd0);
        stq.delete();
        rdq.delete();
        doneq.delete();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rst_mid_word2", mem[(32'h404 >> 2)], 32'd0);
        start_copy(32'h0, 32'h500, 2, k);
        wait_idle();

        // Start pulse during a copy is ignored.
        preload(32'h40, 32'hDEAD_BEEF);
        start_copy(32'h0, 32'h600, 2, k);
        @(negedge i_clk);
        i_start = 1'b1;
        i_src_addr = 32'h40;
        i_dst_addr = 32'h700;
        i_len = 16'd1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_src_addr = 32'd0;
        i_dst_addr = 32'd0;
        i_len = 16'd0;
        wait_idle();
        check("ignored_start_dst", mem[(32'h700 >> 2)], 32'd0);

        // IO window: one word to LEDR.
        preload(32'h20, 32'h0000_00FF);
        exp_d[0] = 32'h0000_00FF;
        start_copy(32'h20, LEDR_ADDR, 1, k);
        wait_idle();
        check("io_ledr", io_ledr, 32'h0000_00FF);

        check("queues_empty", stq.size() + rdq.size() + doneq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
